// File: rtl/memory_controller.sv
// Memory request responder: turns word/byte requests from the control unit into
// one or two byte transfers on an external ready/valid bus, with a per-byte timeout.
module memory_controller #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data_out,
    input  logic              dbl_byte_en,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    output logic [15:0]       mem_data_in,
    output logic              mem_ack,
    output logic              bus_error,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    output logic              ext_we,
    output logic              ext_req,
    input  logic [7:0]        ext_rdata,
    input  logic              ext_ready
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  TO_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [15:0]       r_wdata, w_wdata_next;
    logic              r_dbl, w_dbl_next;
    logic              r_we, w_we_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [15:0]       r_data, w_data_next;
    logic              r_ack, w_ack_next;
    logic              r_berr, w_berr_next;
    logic              r_ext_req, w_ext_req_next;
    logic              r_ext_we, w_ext_we_next;
    logic [ADDR_W-1:0] r_ext_addr, w_ext_addr_next;
    logic [7:0]        r_ext_wdata, w_ext_wdata_next;
    logic              w_timed_out;

    // Abandon a byte phase on the last allowed waiting cycle when ready never came.
    assign w_timed_out = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !ext_ready;

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_dbl_next       = r_dbl;
        w_we_next        = r_we;
        w_cnt_next       = r_cnt;
        w_data_next      = r_data;
        w_ack_next       = 1'b0;
        w_berr_next      = 1'b0;
        w_ext_req_next   = r_ext_req;
        w_ext_we_next    = r_ext_we;
        w_ext_addr_next  = r_ext_addr;
        w_ext_wdata_next = r_ext_wdata;

        case (r_state)
            IDLE: begin
                if (mem_write_en || mem_read_en) begin
                    w_addr_next      = mem_addr;
                    w_wdata_next     = mem_data_out;
                    w_dbl_next       = dbl_byte_en;
                    w_we_next        = mem_write_en;
                    w_data_next      = 16'h0000;
                    w_cnt_next       = '0;
                    w_ext_req_next   = 1'b1;
                    w_ext_we_next    = mem_write_en;
                    w_ext_addr_next  = mem_addr;
                    w_ext_wdata_next = mem_data_out[7:0];
                    w_state_next     = LO;
                end
            end
            LO: begin
                if (ext_ready) begin
                    if (!r_we) begin
                        w_data_next[7:0] = ext_rdata;
                    end
                    if (r_dbl) begin
                        w_cnt_next       = '0;
                        w_ext_addr_next  = r_addr + ADDR_ONE;
                        w_ext_wdata_next = r_wdata[15:8];
                        w_state_next     = HI;
                    end else begin
                        w_ext_req_next = 1'b0;
                        w_ext_we_next  = 1'b0;
                        w_ack_next     = 1'b1;
                        w_state_next   = DONE;
                    end
                end else if (w_timed_out) begin
                    w_data_next    = 16'hFFFF;
                    w_ext_req_next = 1'b0;
                    w_ext_we_next  = 1'b0;
                    w_ack_next     = 1'b1;
                    w_berr_next    = 1'b1;
                    w_state_next   = DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            HI: begin
                if (ext_ready) begin
                    if (!r_we) begin
                        w_data_next[15:8] = ext_rdata;
                    end
                    w_ext_req_next = 1'b0;
                    w_ext_we_next  = 1'b0;
                    w_ack_next     = 1'b1;
                    w_state_next   = DONE;
                end else if (w_timed_out) begin
                    w_data_next    = 16'hFFFF;
                    w_ext_req_next = 1'b0;
                    w_ext_we_next  = 1'b0;
                    w_ack_next     = 1'b1;
                    w_berr_next    = 1'b1;
                    w_state_next   = DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_dbl       <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_berr      <= 1'b0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_dbl       <= w_dbl_next;
            r_we        <= w_we_next;
            r_cnt       <= w_cnt_next;
            r_data      <= w_data_next;
            r_ack       <= w_ack_next;
            r_berr      <= w_berr_next;
            r_ext_req   <= w_ext_req_next;
            r_ext_we    <= w_ext_we_next;
            r_ext_addr  <= w_ext_addr_next;
            r_ext_wdata <= w_ext_wdata_next;
        end
    end

    assign mem_data_in = r_data;
    assign mem_ack     = r_ack;
    assign bus_error   = r_berr;
    assign ext_req     = r_ext_req;
    assign ext_we      = r_ext_we;
    assign ext_addr    = r_ext_addr;
    assign ext_wdata   = r_ext_wdata;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: table of single transactions against a
// bench-side byte responder, plus hand sequences for reset behaviour.
module tb_memory_controller;

    logic        clk;
    logic        nrst;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        dbl_byte_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [15:0] mem_data_in;
    logic        mem_ack;
    logic        bus_error;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic [7:0]  ext_rdata;
    logic        ext_ready;

    int total = 0;
    int bad   = 0;

    localparam int NEVER = 1000;

    memory_controller #(.TIMEOUT(4), .ADDR_W(16)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .dbl_byte_en  (dbl_byte_en),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_ack      (mem_ack),
        .bus_error    (bus_error),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_we       (ext_we),
        .ext_req      (ext_req),
        .ext_rdata    (ext_rdata),
        .ext_ready    (ext_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        dbl;
        logic        rd;
        logic        wr;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          waits;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_ack;
        int          exp_req;
        int          exp_nph;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] wdata,
                                input logic dbl, input logic rd, input logic wr,
                                input logic [7:0] lo, input logic [7:0] hi, input int waits,
                                input logic [15:0] exp_data, input logic exp_err,
                                input int exp_ack, input int exp_req, input int exp_nph,
                                input logic [15:0] exp_a0, input logic [15:0] exp_a1);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.dbl = dbl; v.rd = rd; v.wr = wr;
        v.lo = lo; v.hi = hi; v.waits = waits;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_ack = exp_ack;
        v.exp_req = exp_req; v.exp_nph = exp_nph; v.exp_a0 = exp_a0; v.exp_a1 = exp_a1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issues one request (inputs driven #1 after an edge) and plays the external byte device.
    task automatic run_txn(input vec_t v, input int idx);
        int          k, phase, w, reqcyc, ack_k, nph;
        logic        got_ack, pend, we_ok;
        logic        rec [2];
        logic [15:0] a_seen [2];
        logic [7:0]  d_seen [2];
        logic [15:0] data;
        logic        err;
        string       tag;
        tag = $sformatf("v%0d", idx);
        rec[0] = 1'b0; rec[1] = 1'b0;
        a_seen[0] = '0; a_seen[1] = '0; d_seen[0] = '0; d_seen[1] = '0;
        data = '0; err = 1'b0; ack_k = 0;
        mem_addr = v.addr; mem_data_out = v.wdata; dbl_byte_en = v.dbl;
        mem_read_en = v.rd; mem_write_en = v.wr;
        @(posedge clk); #1;
        k = 0; phase = 0; w = 0; pend = 1'b0; got_ack = 1'b0; reqcyc = 0; we_ok = 1'b1;
        while (!got_ack && k < 40) begin
            if (pend) begin
                phase++;
                w = 0;
            end
            pend = 1'b0;
            if (mem_ack) begin
                got_ack = 1'b1;
                ack_k = k;
                data = mem_data_in;
                err = bus_error;
                mem_read_en = 1'b0;
                mem_write_en = 1'b0;
                ext_ready = 1'b0;
                chk({tag, " req_low_at_ack"}, {31'd0, ext_req}, 32'd0);
            end else begin
                if (ext_req) begin
                    reqcyc++;
                    if (phase < 2 && !rec[phase]) begin
                        rec[phase] = 1'b1;
                        a_seen[phase] = ext_addr;
                        d_seen[phase] = ext_wdata;
                    end
                    if (ext_we !== v.wr) we_ok = 1'b0;
                    if (w < v.waits) begin
                        ext_ready = 1'b0;
                        w++;
                    end else begin
                        ext_ready = 1'b1;
                        ext_rdata = (phase == 0) ? v.lo : v.hi;
                        pend = 1'b1;
                    end
                end else begin
                    ext_ready = 1'b0;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        nph = (rec[0] ? 1 : 0) + (rec[1] ? 1 : 0);
        chk({tag, " ack_seen"}, {31'd0, got_ack}, 32'd1);
        chk({tag, " ack_cycle"}, ack_k + 1, v.exp_ack);
        chk({tag, " data"}, {16'd0, data}, {16'd0, v.exp_data});
        chk({tag, " bus_error"}, {31'd0, err}, {31'd0, v.exp_err});
        chk({tag, " req_cycles"}, reqcyc, v.exp_req);
        chk({tag, " phases"}, nph, v.exp_nph);
        chk({tag, " we"}, {31'd0, we_ok}, 32'd1);
        chk({tag, " addr_lo"}, {16'd0, a_seen[0]}, {16'd0, v.exp_a0});
        if (v.exp_nph == 2) chk({tag, " addr_hi"}, {16'd0, a_seen[1]}, {16'd0, v.exp_a1});
        if (v.wr) begin
            chk({tag, " wdata_lo"}, {24'd0, d_seen[0]}, {24'd0, v.wdata[7:0]});
            if (v.exp_nph == 2) chk({tag, " wdata_hi"}, {24'd0, d_seen[1]}, {24'd0, v.wdata[15:8]});
        end
        @(posedge clk); #1;
        chk({tag, " ack_one_cycle"}, {30'd0, mem_ack, bus_error}, 32'd0);
        chk({tag, " data_held"}, {16'd0, mem_data_in}, {16'd0, v.exp_data});
        $display("txn %s addr=%h ack_at=n+%0d data=%h err=%0d req_cycles=%0d",
                 tag, v.addr, ack_k + 1, data, err, reqcyc);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outs"}, {28'd0, mem_ack, bus_error, ext_req, ext_we}, 32'd0);
        chk({name, " data"}, {16'd0, mem_data_in}, 32'd0);
        chk({name, " ext_addr"}, {16'd0, ext_addr}, 32'd0);
        chk({name, " ext_wdata"}, {24'd0, ext_wdata}, 32'd0);
    endtask

    vec_t tbl [7];
    vec_t after_rst;

    initial begin
        //             addr      wdata    dbl  rd  wr  lo     hi     waits  data      err ack req nph a0        a1
        tbl[0] = mk(16'h0040, 16'h0000, 0, 1, 0, 8'hA5, 8'h00, 0,     16'h00A5, 0, 2, 1, 1, 16'h0040, 16'h0000);
        tbl[1] = mk(16'h1234, 16'h0000, 1, 1, 0, 8'h34, 8'h12, 3,     16'h1234, 0, 9, 8, 2, 16'h1234, 16'h1235);
        tbl[2] = mk(16'hFFFF, 16'hBEEF, 1, 0, 1, 8'h00, 8'h00, 0,     16'h0000, 0, 3, 2, 2, 16'hFFFF, 16'h0000);
        tbl[3] = mk(16'h0100, 16'h0055, 0, 1, 1, 8'h99, 8'h00, 0,     16'h0000, 0, 2, 1, 1, 16'h0100, 16'h0000);
        tbl[4] = mk(16'h2000, 16'h0000, 1, 1, 0, 8'h00, 8'h00, NEVER, 16'hFFFF, 1, 5, 4, 1, 16'h2000, 16'h0000);
        tbl[5] = mk(16'h00FF, 16'h0000, 1, 1, 0, 8'h11, 8'h22, 1,     16'h2211, 0, 5, 4, 2, 16'h00FF, 16'h0100);
        tbl[6] = mk(16'h0003, 16'h0000, 0, 1, 0, 8'h7E, 8'h00, 3,     16'h007E, 0, 5, 4, 1, 16'h0003, 16'h0000);
        after_rst = mk(16'h0042, 16'h0000, 0, 1, 0, 8'h3C, 8'h00, 0,  16'h003C, 0, 2, 1, 1, 16'h0042, 16'h0000);

        nrst = 1'b0; mem_addr = '0; mem_data_out = '0; dbl_byte_en = 1'b0;
        mem_read_en = 1'b0; mem_write_en = 1'b0; ext_rdata = '0; ext_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], i);
        end

        // Reset asserted while the high byte of a word read is outstanding.
        mem_addr = 16'h3000; dbl_byte_en = 1'b1; mem_read_en = 1'b1; mem_write_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid lo_req", {31'd0, ext_req}, 32'd1);
        ext_ready = 1'b1; ext_rdata = 8'h5A;
        @(posedge clk); #1;
        chk("rst_mid hi_addr", {16'd0, ext_addr}, 32'h3001);
        ext_ready = 1'b0; mem_read_en = 1'b0; dbl_byte_en = 1'b0;
        nrst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst_mid");
        @(posedge clk); #1;
        chk("rst_mid no_ack", {31'd0, mem_ack}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid idle_ack", {31'd0, mem_ack}, 32'd0);
        run_txn(after_rst, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
